// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: drives the turn timer, alternates players, requests auto moves on expiry.
// Optional WARN_BLINK_EN macro makes the low-time warning blink instead of holding a steady level.
module turn_controller #(
  parameter int unsigned COLS      = 7,
  parameter int unsigned WARN_SECS = 3,
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       game_over,
  input  logic       move_valid,
  input  logic       timer_expired,
  input  logic [3:0] timer_count,
  input  logic       auto_ack,
  input  logic       auto_nack,
  output logic       timer_reset,
  output logic       timer_enable,
  output logic       player,
  output logic       auto_req,
  output logic [2:0] auto_col,
  output logic       no_moves,
  output logic       warn
);

  localparam int unsigned CW = 3;
  localparam int unsigned TW = 4;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_PLAY,
    S_AUTO_REQ,
    S_AUTO_GAP,
    S_SWITCH,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col_ptr, col_ptr_nx;
  logic [CW-1:0] tries, tries_nx;
  logic [CW-1:0] auto_col_nx;
  logic          player_nx, no_moves_nx;
  logic          timer_reset_nx, timer_enable_nx, auto_req_nx;
  logic          warn_qual;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      col_ptr      <= '0;
      tries        <= '0;
      timer_reset  <= 1'b1;
      timer_enable <= 1'b0;
      player       <= 1'b0;
      auto_req     <= 1'b0;
      auto_col     <= '0;
      no_moves     <= 1'b0;
    end else begin
      state        <= state_nx;
      col_ptr      <= col_ptr_nx;
      tries        <= tries_nx;
      timer_reset  <= timer_reset_nx;
      timer_enable <= timer_enable_nx;
      player       <= player_nx;
      auto_req     <= auto_req_nx;
      auto_col     <= auto_col_nx;
      no_moves     <= no_moves_nx;
    end
  end

  // Next state; outputs are decoded from the state being entered so they land with it
  always_comb begin
    state_nx    = state;
    tries_nx    = tries;
    auto_col_nx = auto_col;
    player_nx   = player;
    no_moves_nx = no_moves;
    col_ptr_nx  = (col_ptr == COL_LAST) ? '0 : col_ptr + CW'(1);

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_ARM;
      end
      S_ARM: state_nx = S_PLAY;
      S_PLAY: begin
        if (game_over) begin
          state_nx = S_DONE;
        end else if (move_valid) begin
          state_nx  = S_SWITCH;
          player_nx = ~player;
        end else if (timer_expired) begin
          state_nx    = S_AUTO_REQ;
          auto_col_nx = col_ptr;
          tries_nx    = '0;
        end
      end
      S_AUTO_REQ: begin
        if (game_over) begin
          state_nx = S_DONE;
        end else if (auto_ack) begin
          state_nx  = S_SWITCH;
          player_nx = ~player;
        end else if (auto_nack) begin
          if ((4'(tries) + 4'd1) == 4'(COLS)) begin
            state_nx    = S_DONE;
            no_moves_nx = 1'b1;
          end else begin
            state_nx    = S_AUTO_GAP;
            tries_nx    = tries + CW'(1);
            auto_col_nx = (auto_col == COL_LAST) ? '0 : auto_col + CW'(1);
          end
        end
      end
      S_AUTO_GAP: state_nx = S_AUTO_REQ;
      S_SWITCH:   state_nx = S_PLAY;
      S_DONE: begin
        if (start) begin
          state_nx    = S_ARM;
          player_nx   = 1'b0;
          no_moves_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    timer_reset_nx  = (state_nx == S_IDLE) || (state_nx == S_ARM) || (state_nx == S_SWITCH);
    timer_enable_nx = (state_nx == S_PLAY);
    auto_req_nx     = (state_nx == S_AUTO_REQ);
  end

  assign warn_qual = (state == S_PLAY) && (timer_count != '0) && (timer_count <= TW'(WARN_SECS));

`ifdef WARN_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  // Blink starts high on the first qualifying cycle and flips every BLINK_DIV cycles
  always_ff @(posedge clk) begin
    if (reset || !warn_qual) begin
      warn      <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (!blink_on) begin
      warn      <= 1'b1;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      warn      <= ~warn;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end
`else
  // BLINK_DIV only shapes the blinking build; an empty block keeps it referenced
  if (BLINK_DIV == 0) begin : g_blink_div_unused
  end

  always_ff @(posedge clk) begin
    if (reset) warn <= 1'b0;
    else       warn <= warn_qual;
  end
`endif

endmodule
